// File: rtl/frame_update_sequencer.sv
// Per-frame scheduler: runs move/spawn/coll/score once per frame tick,
// paces spawning and difficulty, and reports collisions as a die pulse.
module frame_update_sequencer #(
    parameter int SPAWN_PERIOD = 64,
    parameter int LEVEL_FRAMES = 1024,
    parameter int MAX_LEVEL    = 7,
    parameter int TIMEOUT      = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_active,
    input  logic       frame_tick,
    input  logic       move_done,
    input  logic       spawn_done,
    input  logic       coll_done,
    input  logic       score_done,
    input  logic       hit,
    output logic       move_go,
    output logic       spawn_go,
    output logic       coll_go,
    output logic       score_go,
    output logic [2:0] level,
    output logic       busy,
    output logic       die,
    output logic       overrun,
    output logic       stall_err
);

    localparam int SW = $clog2(SPAWN_PERIOD + 1);
    localparam int LW = $clog2(LEVEL_FRAMES + 1);
    localparam logic [SW-1:0] SP_LAST = SW'(SPAWN_PERIOD - 1);
    localparam logic [LW-1:0] LV_LAST = LW'(LEVEL_FRAMES - 1);
    localparam logic [2:0]    LV_MAX  = 3'(MAX_LEVEL);
    localparam logic [7:0]    TO      = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, MOVE, SPAWN, COLL, SCORE
    } state_t;

    state_t        state, state_n;
    logic [7:0]    timer;
    logic [SW-1:0] spawn_cnt;
    logic [LW-1:0] level_cnt;
    logic          timed_out;
    logic          stall_n, die_n, frame_done, clear_game;

    assign timed_out = (timer == TO);

    // Next-state: a stage advances on its own done, else gives up at timeout
    always_comb begin
        state_n    = state;
        stall_n    = 1'b0;
        die_n      = 1'b0;
        frame_done = 1'b0;
        clear_game = 1'b0;
        unique case (state)
            IDLE: begin
                if (!game_active)    clear_game = 1'b1;
                else if (frame_tick) state_n = MOVE;
            end
            MOVE: begin
                if (move_done)
                    state_n = (spawn_cnt == '0) ? SPAWN : COLL;
                else if (timed_out) begin
                    stall_n = 1'b1;
                    state_n = IDLE;
                end
            end
            SPAWN: begin
                if (spawn_done) state_n = COLL;
                else if (timed_out) begin
                    stall_n = 1'b1;
                    state_n = IDLE;
                end
            end
            COLL: begin
                if (coll_done) begin
                    die_n   = hit;
                    state_n = hit ? IDLE : SCORE;
                end else if (timed_out) begin
                    stall_n = 1'b1;
                    state_n = IDLE;
                end
            end
            SCORE: begin
                if (score_done) begin
                    frame_done = 1'b1;
                    state_n    = IDLE;
                end else if (timed_out) begin
                    stall_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Leaving gaming mid-frame wins over any stage outcome
        if (state != IDLE && !game_active) begin
            state_n    = IDLE;
            stall_n    = 1'b0;
            die_n      = 1'b0;
            frame_done = 1'b0;
        end
    end

    // State, registered strobes, stage timer and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            move_go   <= 1'b0;
            spawn_go  <= 1'b0;
            coll_go   <= 1'b0;
            score_go  <= 1'b0;
            busy      <= 1'b0;
            die       <= 1'b0;
            overrun   <= 1'b0;
            stall_err <= 1'b0;
            timer     <= '0;
        end else begin
            state    <= state_n;
            move_go  <= (state_n == MOVE)  && (state != MOVE);
            spawn_go <= (state_n == SPAWN) && (state != SPAWN);
            coll_go  <= (state_n == COLL)  && (state != COLL);
            score_go <= (state_n == SCORE) && (state != SCORE);
            busy     <= (state_n != IDLE);
            die      <= die_n;
            if (stall_n) stall_err <= 1'b1;
            if (frame_tick && state != IDLE) overrun <= 1'b1;
            if (state_n != state || state == IDLE) timer <= '0;
            else                                   timer <= timer + 8'd1;
        end
    end

    // Spawn pacing and difficulty progression on each completed frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spawn_cnt <= '0;
            level_cnt <= '0;
            level     <= '0;
        end else if (clear_game) begin
            spawn_cnt <= '0;
            level_cnt <= '0;
            level     <= '0;
        end else if (frame_done) begin
            spawn_cnt <= (spawn_cnt == SP_LAST) ? '0 : spawn_cnt + 1'b1;
            level_cnt <= (level_cnt == LV_LAST) ? '0 : level_cnt + 1'b1;
            if (level_cnt == LV_LAST && level < LV_MAX)
                level <= level + 3'd1;
        end
    end

endmodule

// File: tb/tb_frame_update_sequencer.sv
// Directed bench for frame_update_sequencer with a strobe scoreboard:
// expected go/die events are queued per frame and matched on output.
module tb_frame_update_sequencer;

    localparam int TO = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_active = 1'b0;
    logic       frame_tick = 1'b0;
    logic       hit = 1'b0;
    logic       move_done, spawn_done, coll_done, score_done;
    logic       move_go, spawn_go, coll_go, score_go;
    logic [2:0] level;
    logic       busy, die, overrun, stall_err;
    logic       auto_mv = 1'b1, auto_sp = 1'b1;
    logic       auto_cl = 1'b1, auto_sc = 1'b1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [4:0] code;
        int         at;
    } ev_t;
    ev_t sb[$];

    assign move_done  = auto_mv & move_go;
    assign spawn_done = auto_sp & spawn_go;
    assign coll_done  = auto_cl & coll_go;
    assign score_done = auto_sc & score_go;

    frame_update_sequencer #(
        .SPAWN_PERIOD(4),
        .LEVEL_FRAMES(2),
        .MAX_LEVEL(3),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .game_active(game_active),
        .frame_tick(frame_tick),
        .move_done(move_done),
        .spawn_done(spawn_done),
        .coll_done(coll_done),
        .score_done(score_done),
        .hit(hit),
        .move_go(move_go),
        .spawn_go(spawn_go),
        .coll_go(coll_go),
        .score_go(score_go),
        .level(level),
        .busy(busy),
        .die(die),
        .overrun(overrun),
        .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [4:0] code, input int at);
        ev_t e;
        e.code = code;
        e.at   = at;
        sb.push_back(e);
    endtask

    // Match every go/die strobe against the oldest queued expectation
    always @(negedge clk) begin
        logic [4:0] code;
        ev_t e;
        code = {die, score_go, coll_go, spawn_go, move_go};
        if (code != 5'd0) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", int'(code), 0);
            end else begin
                e = sb.pop_front();
                chk("ev_code", int'(code), int'(e.code));
                chk("ev_cycle", cyc, e.at);
            end
        end
    end

    // One frame: queue its strobes, tick, optional mid-frame tick at
    // offset extra, then require the return to idle on the exact cycle
    task automatic run_frame(input bit sp, input bit hit_i,
                             input bit stall, input int extra);
        int t0, c, idle, n;
        t0  = cyc;
        hit = hit_i;
        push(5'd1, t0 + 1);
        if (stall) begin
            idle = t0 + 1 + TO + 1;
        end else begin
            c = t0 + 2;
            if (sp) begin
                push(5'd2, c);
                c++;
            end
            push(5'd4, c);
            if (hit_i) begin
                push(5'd16, c + 1);
                idle = c + 1;
            end else begin
                push(5'd8, c + 1);
                idle = c + 2;
            end
        end
        frame_tick = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            frame_tick = (extra != 0) && (cyc == t0 + extra);
            n++;
        end while (busy && n < 40);
        chk("idle_cycle", cyc, idle);
        hit = 1'b0;
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        chk("rst_outputs",
            int'({move_go, spawn_go, coll_go, score_go, level,
                  busy, die, overrun, stall_err}), 0);
        rst = 1'b0;
        game_active = 1'b1;
        @(negedge clk);

        // Ten clean frames: spawn on 0,4,8; level 1,2,3 after 2,4,6
        for (int f = 0; f < 10; f++) begin
            run_frame((f % 4) == 0, 1'b0, 1'b0, 0);
            chk("level_step", int'(level), ((f + 1) / 2 > 3) ? 3 : (f + 1) / 2);
        end

        // Collision: die pulse, no score, level untouched
        run_frame(1'b0, 1'b1, 1'b0, 0);
        chk("level_after_die", int'(level), 3);
        @(negedge clk);
        chk("die_single", int'(die), 0);

        // Leaving the game while idle resets difficulty and spawn pacing
        game_active = 1'b0;
        repeat (2) @(negedge clk);
        chk("level_cleared", int'(level), 0);
        game_active = 1'b1;
        @(negedge clk);
        run_frame(1'b1, 1'b0, 1'b0, 0);

        // Stall: move_done withheld until the stage times out
        auto_mv = 1'b0;
        run_frame(1'b0, 1'b0, 1'b1, 0);
        chk("stall_flag", int'(stall_err), 1);
        chk("no_overrun_yet", int'(overrun), 0);
        auto_mv = 1'b1;

        // Overrun: second tick mid-frame is dropped and flagged
        run_frame(1'b0, 1'b0, 1'b0, 2);
        chk("overrun_flag", int'(overrun), 1);
        chk("stall_sticky", int'(stall_err), 1);

        // Abort while waiting in COLL
        auto_cl = 1'b0;
        t0 = cyc;
        push(5'd1, t0 + 1);
        push(5'd4, t0 + 2);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        game_active = 1'b0;
        @(negedge clk);
        chk("abort_idle", int'(busy), 0);
        chk("abort_no_die", int'(die), 0);
        @(negedge clk);
        chk("abort_no_die2", int'(die), 0);
        auto_cl = 1'b1;
        game_active = 1'b1;
        @(negedge clk);

        // Reset asserted during SCORE clears everything at once
        t0 = cyc;
        push(5'd1, t0 + 1);
        push(5'd2, t0 + 2);
        push(5'd4, t0 + 3);
        push(5'd8, t0 + 4);
        auto_sc = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("in_score", int'(score_go), 1);
        chk("flags_before_rst", int'({overrun, stall_err}), 3);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_outputs",
            int'({move_go, spawn_go, coll_go, score_go, level,
                  busy, die, overrun, stall_err}), 0);
        @(negedge clk);
        rst = 1'b0;
        auto_sc = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_quiet", int'({busy, die}), 0);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_update_sequencer.md
# frame_update_sequencer

Per-frame scheduler for the game datapath. While the game is in the gaming state, it sequences the move, spawn, collision and score units once per VGA frame tick, using a go/done handshake with each unit. It also paces obstacle spawning and the difficulty level, and returns a one-cycle `die` pulse to the top-level game state machine when a collision is reported.

## Interface
- `SPAWN_PERIOD`, 64: frames between obstacle spawns; ≥1.
- `LEVEL_FRAMES`, 1024: completed frames per level step; ≥1.
- `MAX_LEVEL`, 7: level saturation value; ≤7.
- `TIMEOUT`, 255: max cycles spent waiting in any stage; 1..255.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `game_active`  in  1  1 while game state machine is in gaming
- `frame_tick`  in  1  one-cycle pulse at start of vertical blanking
- `move_done`, `spawn_done`, `coll_done`, `score_done`  in  1 each  stage-complete strobes from datapath units
- `hit`  in  1  collision result; valid only while `coll_done`=1
- `move_go`, `spawn_go`, `coll_go`, `score_go`  out  1 each  one-cycle stage start pulses
- `level`  out  3  current difficulty level
- `busy`  out  1  1 whenever state ≠ IDLE
- `die`  out  1  one-cycle pulse on detected collision
- `overrun`  out  1  sticky: frame_tick arrived while busy
- `stall_err`  out  1  sticky: a stage timed out

## Operation
- States: IDLE, MOVE, SPAWN, COLL, SCORE. All outputs registered.
- Reset: state=IDLE, all go pulses 0, `die`=0, `busy`=0, `level`=0, `overrun`=0, `stall_err`=0, internal spawn_cnt=0, level_cnt=0, timer=0.
- IDLE: if `game_active` and `frame_tick`, go to MOVE.
- The matching go pulse is high during the first cycle in each stage state only. The timer clears on every state entry.
- `done` is accepted in any cycle of its stage, including the first (same cycle as go). Done strobes for other stages are ignored.
- MOVE + `move_done`: go to SPAWN if spawn_cnt==0, else COLL.
- SPAWN + `spawn_done`: go to COLL.
- COLL + `coll_done`:
  - If `hit`=1: `die` pulses on the next cycle, go to IDLE. The frame is not counted.
  - Otherwise go to SCORE.
- SCORE + `score_done`: go to IDLE. The frame completes.
  - spawn_cnt increments and wraps from SPAWN_PERIOD-1 to 0.
  - level_cnt increments and wraps from LEVEL_FRAMES-1 to 0. On that wrap, `level` increments, saturating at MAX_LEVEL.
- Timeout: if the timer reaches TIMEOUT in any stage without its done, set `stall_err`, go to IDLE. Counters are unchanged.
- `frame_tick` while state≠IDLE: the tick is dropped and `overrun` is set. If the tick coincides with the exact cycle a sequence returns to IDLE, it is also dropped.
- `game_active`=0 in any non-IDLE state: abort to IDLE next cycle. No further go pulses, no `die`.
- `game_active`=0 while IDLE: spawn_cnt, level_cnt and `level` clear to 0. The next game starts at level 0 and spawns on its first frame.
- `overrun` and `stall_err` clear only on `rst`.
- `rst` mid-sequence: immediate return to reset values. No pending pulse survives.

## Timing
- `frame_tick` high at cycle T in IDLE: state=MOVE and `move_go`=1 at T+1.
- Zero-wait units (done in the same cycle as go): `move_go` T+1, `spawn_go` T+2 (if due), `coll_go` T+3, `score_go` T+4, IDLE at T+5. Without a spawn, each step is one cycle earlier.
- `die` is high exactly one cycle, the cycle after `coll_done`·`hit`. `busy` is 0 in that cycle.
- `level` updates the cycle after the qualifying `score_done`.
- Timeout fires when timer==TIMEOUT, i.e. TIMEOUT+1 cycles after stage entry. IDLE follows next cycle.

## Test plan
- Zero-wait frame, spawn due: `game_active`=1, tick at T, all dones tied to their go pulses → go pulses at T+1..T+4 in order move/spawn/coll/score, `busy` 0 at T+5.
- Spawn pacing: SPAWN_PERIOD=4, run 9 clean frames → `spawn_go` only in frames 0, 4 and 8.
- Collision: `coll_done`=1 with `hit`=1 → single-cycle `die`, no `score_go`, state IDLE, `level` unchanged.
- Level saturation: LEVEL_FRAMES=2, MAX_LEVEL=3, run 10 frames → `level` steps 1,2,3 after frames 2,4,6, then holds 3. Drop `game_active` in IDLE → `level`=0.
- Stall and overrun: TIMEOUT=5, withhold `move_done` → `stall_err`=1 six cycles after entry, then IDLE. A tick during a frame sets `overrun`, and both flags survive until `rst`.
- Abort and reset: drop `game_active` while in COLL → IDLE next cycle, no `die`. Assert `rst` in SCORE → all outputs 0 immediately.
